line_buf_sched: RTL

- Controller for the 3x3 window line-buffer stage of the pixel pipeline.
- Accepts a raster pixel-valid stream.
- Rotates the write target among four 8-bit line buffers and generates their write strobes and addresses.
- Drives the 2-bit select codes of the three downstream 4:1 pixel selectors, one per window row (top/mid/bot), so each selector always presents the correct buffer for its row.

---
 rtl/line_buf_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/line_buf_sched.sv
// rtl/line_buf_sched.sv - write/read scheduler for the 3x3 window line-buffer stage
//
// Rotates writes among four line buffers, drives their write strobes and
// column address, and registers the shared read address plus the 4:1 selector
// codes for the top/mid/bot window rows. Optional feature macro:
// LBSCHED_GAP_CNT_EN adds o_gap_cnt (saturating count of idle cycles in RUN).
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   i_sof               start of frame, restarts all counters
//   i_pix_valid         one pixel on the stream this cycle
//   o_wr_en[3:0]        one-hot line-buffer write enable (combinational)
//   o_wr_addr           write column (combinational)
//   o_rd_addr           read column, shared by all buffers (registered)
//   o_sel_top/mid/bot   selector codes per window row (registered)
//   o_win_valid         window column at o_rd_addr is valid (registered)
//   o_frame_done        one-cycle pulse after the last pixel of a frame
//   o_gap_cnt[15:0]     only with LBSCHED_GAP_CNT_EN

module line_buf_sched #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sof,
  input  logic              i_pix_valid,
  output logic [3:0]        o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [1:0]        o_sel_top,
  output logic [1:0]        o_sel_mid,
  output logic [1:0]        o_sel_bot,
  output logic              o_win_valid,
  output logic              o_frame_done
`ifdef LBSCHED_GAP_CNT_EN
  ,
  output logic [15:0]       o_gap_cnt
`endif
);

  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        wbuf;
  logic [ADDR_W-1:0] col;
  logic [ROW_W-1:0]  row;

  // A start-of-frame takes effect in the same cycle, so a pixel arriving with
  // it is treated as column 0 / row 0 of the new frame in buffer 0.
  state_t            eff_state;
  logic [1:0]        eff_wbuf;
  logic [ADDR_W-1:0] eff_col;
  logic [ROW_W-1:0]  eff_row;
  logic              accept;

  assign eff_state = i_sof ? S_FILL : state;
  assign eff_wbuf  = i_sof ? 2'd0 : wbuf;
  assign eff_col   = i_sof ? '0 : col;
  assign eff_row   = i_sof ? '0 : row;
  assign accept    = i_pix_valid && (eff_state != S_DONE);

  always_comb begin
    o_wr_en = 4'b0000;
    if (accept) begin
      o_wr_en = 4'b0001 << eff_wbuf;
    end
  end

  assign o_wr_addr = eff_col;

`ifdef LBSCHED_GAP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || i_sof) begin
      o_gap_cnt <= 16'h0000;
    end else if (state == S_RUN && !i_pix_valid && o_gap_cnt != 16'hFFFF) begin
      o_gap_cnt <= o_gap_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_FILL;
      wbuf         <= 2'd0;
      col          <= '0;
      row          <= '0;
      o_rd_addr    <= '0;
      o_sel_top    <= 2'd0;
      o_sel_mid    <= 2'd0;
      o_sel_bot    <= 2'd0;
      o_win_valid  <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_win_valid  <= 1'b0;
      o_frame_done <= 1'b0;

      if (i_sof) begin
        state <= S_FILL;
        wbuf  <= 2'd0;
        col   <= '0;
        row   <= '0;
      end

      if (accept) begin
        // Selector code is (buffer+1) mod 4; the top row lives in wbuf+1,
        // mid in wbuf+2 and bot in wbuf+3 (the three most recent full lines).
        o_rd_addr   <= eff_col;
        o_sel_top   <= eff_wbuf + 2'd2;
        o_sel_mid   <= eff_wbuf + 2'd3;
        o_sel_bot   <= eff_wbuf;
        o_win_valid <= (eff_state == S_RUN);

        if (eff_col == COL_LAST) begin
          col  <= '0;
          wbuf <= eff_wbuf + 2'd1;
          row  <= (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
          if (eff_state == S_FILL && eff_row == ROW_W'(2)) begin
            state <= S_RUN;
          end
          if (eff_state == S_RUN && eff_row == ROW_LAST) begin
            state        <= S_DONE;
            o_frame_done <= 1'b1;
          end
        end else begin
          col <= eff_col + ADDR_W'(1);
        end
      end
    end
  end

endmodule
